seq_frame_tx: RTL and testbench

Serial frame transmitter that pairs with the team's serial sequence detector.
- Accepts a parallel data word through a load/ready handshake.
- Emits one bit per clock on a single serial line: sync pattern (default 4'b1101), then data MSB-first, then an optional even-parity bit, then idle gap cycles.
- Drives the detector's `in` pin in system-level and loopback benches.

---
 rtl/seq_frame_tx_if.sv | 25 ++
 rtl/seq_frame_tx.sv | 150 +++++++++++++++
 tb/tb_seq_frame_tx.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/seq_frame_tx_if.sv
// Handshake and serial-line bundle between a word source and seq_frame_tx.
// Latency: none, wires only.
// Backpressure: the source holds load until it sees ready; load is ignored while busy.
interface seq_frame_tx_if #(
  parameter int DATA_W = 8
);
  logic              load;
  logic [DATA_W-1:0] data_in;
  logic              ready;
  logic              busy;
  logic              out;
  logic              frame_done;

  // Word source side.
  modport master (
    output load, data_in,
    input  ready, busy, out, frame_done
  );

  // Transmitter side.
  modport slave (
    input  load, data_in,
    output ready, busy, out, frame_done
  );
endinterface

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: sync pattern, payload MSB-first, optional even parity, idle gap.
// Latency: first sync bit on out one cycle after the accepting edge; all outputs registered.
// Backpressure: ready only in IDLE; load while busy is dropped, never queued.
module seq_frame_tx #(
  parameter int                DATA_W = 8,
  parameter int                SYNC_W = 4,
  parameter logic [SYNC_W-1:0] SYNC   = 4'b1101,
  parameter bit                PARITY = 1'b1,
  parameter int                GAP    = 2
) (
  input logic          clk,
  input logic          rst,
  seq_frame_tx_if.slave bus
);

  // One counter serves the sync, data and gap phases, so size it for the longest.
  localparam int MAX_A = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
  localparam int MAXC  = (MAX_A > GAP) ? MAX_A : GAP;
  localparam int CW    = $clog2(MAXC + 1);

  localparam logic [CW-1:0] ONE       = CW'(1);
  localparam logic [CW-1:0] SYNC_LAST = CW'(SYNC_W);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_PAR,
    ST_GAP
  } state_t;

  // Where a frame lands once its last payload/parity bit has been driven.
  localparam state_t        AFTER_STATE = (GAP == 0) ? ST_IDLE : ST_GAP;
  localparam logic [CW-1:0] AFTER_CNT   = (GAP == 0) ? '0 : ONE;

  state_t              state_q, state_d;
  logic                out_q = 1'b0;
  logic                out_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [SYNC_W-1:0]   sync_q, sync_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                par_q, par_d;
  logic                done_q, done_d;

  // cnt counts bits of the current phase already placed on out, so terminal is equality with the phase length.
  always_comb begin
    state_d = state_q;
    out_d   = 1'b0;
    shreg_d = shreg_q;
    sync_d  = sync_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.load) begin
          state_d = ST_SYNC;
          out_d   = SYNC[SYNC_W-1];
          sync_d  = SYNC << 1;
          shreg_d = bus.data_in;
          cnt_d   = ONE;
          par_d   = 1'b0;
        end
      end
      ST_SYNC: begin
        if (cnt_q == SYNC_LAST) begin
          state_d = ST_DATA;
          out_d   = shreg_q[DATA_W-1];
          par_d   = shreg_q[DATA_W-1];
          shreg_d = shreg_q << 1;
          cnt_d   = ONE;
        end else begin
          out_d  = sync_q[SYNC_W-1];
          sync_d = sync_q << 1;
          cnt_d  = cnt_q + ONE;
        end
      end
      ST_DATA: begin
        if (cnt_q == DATA_LAST) begin
          if (PARITY) begin
            state_d = ST_PAR;
            out_d   = par_q;
          end else begin
            state_d = AFTER_STATE;
            cnt_d   = AFTER_CNT;
            done_d  = 1'b1;
          end
        end else begin
          out_d   = shreg_q[DATA_W-1];
          par_d   = par_q ^ shreg_q[DATA_W-1];
          shreg_d = shreg_q << 1;
          cnt_d   = cnt_q + ONE;
        end
      end
      ST_PAR: begin
        state_d = AFTER_STATE;
        cnt_d   = AFTER_CNT;
        done_d  = 1'b1;
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State register; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers; reset clears the word so an abandoned frame never resurfaces.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= 1'b0;
      shreg_q <= '0;
      sync_q  <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      out_q   <= out_d;
      shreg_q <= shreg_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      done_q  <= done_d;
    end
  end

  assign bus.out        = out_q;
  assign bus.frame_done = done_q;
  assign bus.ready      = (state_q == ST_IDLE);
  assign bus.busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_seq_frame_tx.sv
// Directed bench for seq_frame_tx: one parity and one no-parity instance share stimulus.
// Latency: observes every output on the falling edge, half a cycle after it is registered.
// Backpressure: waits (bounded) for ready before each load.
module tb_seq_frame_tx;

  logic       clk;
  logic       rst;
  logic       load;
  logic       sel;
  logic [7:0] data;

  logic obs_out, obs_ready, obs_busy, obs_fd;

  int tests = 0;
  int fails = 0;

  seq_frame_tx_if #(.DATA_W(8)) pif ();
  seq_frame_tx_if #(.DATA_W(8)) nif ();

  seq_frame_tx #(
    .DATA_W(8), .SYNC_W(4), .SYNC(4'b1101), .PARITY(1'b1), .GAP(2)
  ) dut_par (
    .clk(clk), .rst(rst), .bus(pif)
  );

  seq_frame_tx #(
    .DATA_W(8), .SYNC_W(4), .SYNC(4'b1101), .PARITY(1'b0), .GAP(2)
  ) dut_nopar (
    .clk(clk), .rst(rst), .bus(nif)
  );

  assign pif.load    = load & sel;
  assign nif.load    = load & ~sel;
  assign pif.data_in = data;
  assign nif.data_in = data;

  assign obs_out   = sel ? pif.out        : nif.out;
  assign obs_ready = sel ? pif.ready      : nif.ready;
  assign obs_busy  = sel ? pif.busy       : nif.busy;
  assign obs_fd    = sel ? pif.frame_done : nif.frame_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic [7:0]  d;
    logic [12:0] exp;
    int          len;
    string       nm;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_ready(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      ok = obs_ready;
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL %s_ready_timeout: ready stayed 0, expected 1 within 64 cycles", nm);
    end
  endtask

  // Sends one word and checks every cycle of the frame, its gap and the return to IDLE.
  task automatic run_frame(input logic s, input logic [7:0] d, input logic [12:0] exp,
                           input int len, input string nm);
    sel = s;
    wait_ready(nm);
    data = d;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int k = 1; k <= len + 3; k++) begin
      if (k > 1) @(negedge clk);
      chk($sformatf("%s_out_c%0d", nm, k), {31'd0, obs_out},
          {31'd0, (k <= len) ? exp[13-k] : 1'b0});
      chk($sformatf("%s_fd_c%0d", nm, k), {31'd0, obs_fd}, {31'd0, k == len + 1});
      chk($sformatf("%s_rdy_c%0d", nm, k), {31'd0, obs_ready}, {31'd0, k == len + 3});
      chk($sformatf("%s_busy_c%0d", nm, k), {31'd0, obs_busy}, {31'd0, k != len + 3});
    end
  endtask

  initial begin
    logic [12:0] ff_exp;
    logic [12:0] zz_exp;
    logic [3:0]  hist;
    int          pulses;
    int          pulse_at;
    int          fd_cnt;
    logic        e_out;

    // Frames written as sync + payload (+ parity), MSB first, left aligned in 13 bits.
    vecs[0] = '{1'b1, 8'hA5, 13'b1101_1010_0101_0, 13, "a5_par"};
    vecs[1] = '{1'b1, 8'h07, 13'b1101_0000_0111_1, 13, "07_par"};
    vecs[2] = '{1'b0, 8'h07, 13'b1101_0000_0111_0, 12, "07_nopar"};
    vecs[3] = '{1'b0, 8'h80, 13'b1101_1000_0000_0, 12, "80_nopar"};
    vecs[4] = '{1'b1, 8'h01, 13'b1101_0000_0001_1, 13, "01_par"};
    vecs[5] = '{1'b0, 8'hFF, 13'b1101_1111_1111_0, 12, "ff_nopar"};
    vecs[6] = '{1'b1, 8'h6B, 13'b1101_0110_1011_1, 13, "6b_par"};
    ff_exp  = 13'b1101_1111_1111_0;
    zz_exp  = 13'b1101_0000_0000_0;

    rst  = 1'b1;
    load = 1'b0;
    sel  = 1'b1;
    data = 8'h00;

    #1;
    chk("t0_out_par", {31'd0, pif.out}, 32'd0);
    chk("t0_out_nopar", {31'd0, nif.out}, 32'd0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, obs_ready}, 32'd1);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("idle_out_c%0d", k), {31'd0, obs_out}, 32'd0);
      chk($sformatf("idle_rdy_c%0d", k), {31'd0, obs_ready}, 32'd1);
      chk($sformatf("idle_busy_c%0d", k), {31'd0, obs_busy}, 32'd0);
      chk($sformatf("idle_fd_c%0d", k), {31'd0, obs_fd}, 32'd0);
    end

    for (int v = 0; v < 7; v++) begin
      run_frame(vecs[v].s, vecs[v].d, vecs[v].exp, vecs[v].len, vecs[v].nm);
    end

    // Load held high across two words: second frame follows the single ready cycle.
    sel = 1'b1;
    wait_ready("hold");
    data   = 8'hFF;
    load   = 1'b1;
    fd_cnt = 0;
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      if (k == 1) data = 8'h00;
      if (k == 30) load = 1'b0;
      if (k <= 13) e_out = ff_exp[13-k];
      else if (k >= 17 && k <= 29) e_out = zz_exp[13-(k-16)];
      else e_out = 1'b0;
      if (obs_fd) fd_cnt++;
      chk($sformatf("hold_out_c%0d", k), {31'd0, obs_out}, {31'd0, e_out});
      chk($sformatf("hold_rdy_c%0d", k), {31'd0, obs_ready}, {31'd0, (k == 16) || (k >= 32)});
      chk($sformatf("hold_fd_c%0d", k), {31'd0, obs_fd}, {31'd0, (k == 14) || (k == 30)});
    end
    chk("hold_fd_count", fd_cnt, 2);

    // Reset during the third payload bit abandons the frame silently.
    sel = 1'b1;
    wait_ready("rstmid");
    data = 8'hA5;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int k = 2; k <= 7; k++) @(negedge clk);
    chk("rstmid_bit3", {31'd0, obs_out}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid_out", {31'd0, obs_out}, 32'd0);
    chk("rstmid_rdy", {31'd0, obs_ready}, 32'd1);
    chk("rstmid_busy", {31'd0, obs_busy}, 32'd0);
    chk("rstmid_fd", {31'd0, obs_fd}, 32'd0);
    fd_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (obs_fd || obs_out || !obs_ready) fd_cnt++;
    end
    chk("rstmid_quiet", fd_cnt, 0);
    run_frame(1'b1, 8'h3C, 13'b1101_0011_1100_0, 13, "3c_after_rst");

    // Loopback into a 1101 detector model fed by out.
    sel = 1'b1;
    wait_ready("loop");
    data     = 8'h00;
    load     = 1'b1;
    hist     = 4'b0000;
    pulses   = 0;
    pulse_at = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) load = 1'b0;
      hist = {hist[2:0], obs_out};
      if (hist == 4'b1101) begin
        pulses++;
        pulse_at = k;
      end
    end
    chk("loop_pulses", pulses, 1);
    chk("loop_align", pulse_at, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
    $fatal(1);
  end

endmodule
